fifo_stream_reader: RTL

- Read-side companion to the team's dual-clock FIFO; lives entirely in the FIFO read clock domain.
- On a start command it pops exactly len words from the FIFO's first-word-fall-through read port and presents them on a valid/ready stream, flagging the final word with m_last.
- Decouples FIFO pops from downstream backpressure with a 2-entry output buffer; sits between the FIFO and consumers such as DMA or serializers.

---
 rtl/fifo_stream_reader_pkg.sv | 10 +
 rtl/fifo_stream_reader_skid.sv | 79 +++++++
 rtl/fifo_stream_reader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for fifo_stream_reader: FSM state encoding and output buffer depth.
package fifo_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry in-order data+last buffer between FIFO pops and the output stream.
module fifo_stream_reader_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last
);

  logic [DATA_WIDTH-1:0] head_data_r;
  logic [DATA_WIDTH-1:0] tail_data_r;
  logic                  head_last_r;
  logic                  tail_last_r;
  logic [1:0]            occ_r;
  logic                  pop_ok_s;

  assign pop_ok_s  = pop && (occ_r != 2'd0);
  assign occ       = occ_r;
  assign head_data = head_data_r;
  assign head_last = head_last_r;

  // Head always holds the oldest word; a flush only clears occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_r <= {DATA_WIDTH{1'b0}};
      tail_data_r <= {DATA_WIDTH{1'b0}};
      head_last_r <= 1'b0;
      tail_last_r <= 1'b0;
      occ_r       <= 2'd0;
    end else if (flush) begin
      occ_r <= 2'd0;
    end else begin
      case (occ_r)
        2'd0: begin
          if (push) begin
            head_data_r <= push_data;
            head_last_r <= push_last;
            occ_r       <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop_ok_s) begin
            head_data_r <= push_data;
            head_last_r <= push_last;
          end else if (push) begin
            tail_data_r <= push_data;
            tail_last_r <= push_last;
            occ_r       <= 2'd2;
          end else if (pop_ok_s) begin
            occ_r <= 2'd0;
          end
        end
        2'(BUF_DEPTH): begin
          if (pop_ok_s) begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            if (push) begin
              tail_data_r <= push_data;
              tail_last_r <= push_last;
            end else begin
              occ_r <= 2'd1;
            end
          end
        end
        default: occ_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops len words from a FWFT FIFO onto a valid/ready stream with m_last on the final word.
// Optional starvation timeout enabled by defining FIFO_STREAM_READER_TIMEOUT_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  rclk,
  input  logic                  rreset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic [ADDR_WIDTH-1:0] fifo_used,
  output logic [ADDR_WIDTH-1:0] stat_used,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  timeout_err
);

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [LEN_WIDTH-1:0]  remaining_r;
  logic [ADDR_WIDTH-1:0] stat_used_r;
  logic [1:0]            occ_s;
  logic                  load_s;
  logic                  hs_s;
  logic                  pop_s;
  logic                  drained_s;
  logic                  kill_s;
  logic                  timeout_hit_s;

  assign m_valid   = (occ_s != 2'd0);
  assign hs_s      = m_valid && m_ready;
  assign kill_s    = abort && (state_r != ST_IDLE);
  assign pop_s     = (state_r == ST_STREAM) && (remaining_r != {LEN_WIDTH{1'b0}}) &&
                     !fifo_empty && !abort && (occ_s < 2'(BUF_DEPTH));
  // Buffer will be empty after this edge, so done lands the cycle after the last handshake.
  assign drained_s = (occ_s == 2'd0) || ((occ_s == 2'd1) && hs_s && !pop_s);
  assign fifo_re   = pop_s;
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_FINISH);
  assign stat_used = stat_used_r;

  fifo_stream_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (rclk),
    .rst      (rreset),
    .flush    (kill_s || timeout_hit_s),
    .push     (pop_s),
    .push_data(fifo_rdata),
    .push_last(remaining_r == LEN_WIDTH'(1)),
    .pop      (hs_s),
    .occ      (occ_s),
    .head_data(m_data),
    .head_last(m_last)
  );

`ifdef FIFO_STREAM_READER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_err_r;
  logic            starve_s;

  assign starve_s      = (state_r == ST_STREAM) && (remaining_r != {LEN_WIDTH{1'b0}}) && fifo_empty;
  assign timeout_hit_s = starve_s && !abort && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err   = timeout_err_r;

  // Consecutive starved cycles; any non-starved cycle (including a pop) restarts the count.
  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (starve_s && !timeout_hit_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= {TO_W{1'b0}};
    end
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      timeout_err_r <= 1'b0;
    end else if (load_s) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
  end
`endif

  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = (len != {LEN_WIDTH{1'b0}}) ? ST_STREAM : ST_FINISH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          state_nxt_s = ST_FINISH;
        end else if ((remaining_r == {LEN_WIDTH{1'b0}}) && drained_s) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Decrement only on a pop, which requires remaining != 0, so the count never wraps.
  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      remaining_r <= {LEN_WIDTH{1'b0}};
    end else if (load_s) begin
      remaining_r <= len;
    end else if (kill_s || timeout_hit_s) begin
      remaining_r <= {LEN_WIDTH{1'b0}};
    end else if (pop_s) begin
      remaining_r <= remaining_r - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      stat_used_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      stat_used_r <= fifo_used;
    end
  end

endmodule
